// File: rtl/nanov_digit_alu.sv
// nanov_digit_alu: digit-serial integer ALU. It streams XLEN-bit operands LSB-first,
// DIGIT_W bits per enabled beat.
// It always computes eq / signed-lt / unsigned-lt flags from an internal a-b path.
// Optional feature macro: NANOV_SHIFT_EN. When defined, it adds SLL/SRL/SRA,
// the OUT state and the XLEN-bit operand buffer. When undefined, ops 7-9 act as reserved.
module nanov_digit_alu #(
    parameter int DIGIT_W = 1,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [4:0]         shamt,
    input  logic               en,
    input  logic [DIGIT_W-1:0] a_in,
    input  logic [DIGIT_W-1:0] b_in,
    output logic [DIGIT_W-1:0] res_out,
    output logic               res_valid,
    output logic               busy,
    output logic               done,
    output logic               flag_eq,
    output logic               flag_lt,
    output logic               flag_ltu
);

    localparam int N  = XLEN / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } op_t;

`ifdef NANOV_SHIFT_EN
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    op_t             op_q;
    logic            carry, fcarry, feq;
    logic            h_eq, h_lt, h_ltu;

    logic            first, last;
    logic            ci;
    logic [DIGIT_W-1:0] bx;
    logic [DIGIT_W:0]   add_full, sub_full;
    logic            eq_now, lt_now, ltu_now;
    logic            cur_eq, cur_lt, cur_ltu;
    logic            is_shift;

`ifdef NANOV_SHIFT_EN
    logic [4:0]      shamt_q;
    logic [XLEN-1:0] buf_q, buf_in, shifted;
    logic            p_eq, p_lt, p_ltu;
`else
    logic            unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    // Per-beat arithmetic: op-dependent adder plus an op-independent a-b flag path
    always_comb begin
        first    = (cnt == '0);
        last     = (cnt == LAST);
        ci       = first ? (op_q == OP_SUB) : carry;
        bx       = (op_q == OP_SUB) ? ~b_in : b_in;
        add_full = {1'b0, a_in} + {1'b0, bx} + {{DIGIT_W{1'b0}}, ci};
        sub_full = {1'b0, a_in} + {1'b0, ~b_in} + {{DIGIT_W{1'b0}}, (first ? 1'b1 : fcarry)};
        // a==b exactly when every digit of a-b is zero
        eq_now   = (first | feq) & (sub_full[DIGIT_W-1:0] == '0);
        ltu_now  = ~sub_full[DIGIT_W];
        lt_now   = (a_in[DIGIT_W-1] != b_in[DIGIT_W-1]) ? a_in[DIGIT_W-1]
                                                        : sub_full[DIGIT_W-1];
`ifdef NANOV_SHIFT_EN
        is_shift = (op_q inside {OP_SLL, OP_SRL, OP_SRA});
`else
        is_shift = 1'b0;
`endif
    end

`ifdef NANOV_SHIFT_EN
    // Shift network applied to the fully assembled operand on the last RUN beat
    always_comb begin
        buf_in = {a_in, buf_q[XLEN-1:DIGIT_W]};
        case (op_q)
            OP_SLL:  shifted = buf_in << shamt_q;
            OP_SRL:  shifted = buf_in >> shamt_q;
            OP_SRA:  shifted = $signed(buf_in) >>> shamt_q;
            default: shifted = buf_in;
        endcase
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                if (en && last) begin
`ifdef NANOV_SHIFT_EN
                    state_nx = is_shift ? OUT : IDLE;
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef NANOV_SHIFT_EN
            OUT: if (en && last) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: zero-latency result digits, done strobe, flag presentation
    always_comb begin
        res_out   = '0;
        res_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        cur_eq    = eq_now;
        cur_lt    = lt_now;
        cur_ltu   = ltu_now;
`ifdef NANOV_SHIFT_EN
        if (state == OUT) begin
            cur_eq  = p_eq;
            cur_lt  = p_lt;
            cur_ltu = p_ltu;
        end
`endif
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                RUN: begin
                    if (en) begin
                        done = last && !is_shift;
                        case (op_q)
                            OP_ADD, OP_SUB: begin res_out = add_full[DIGIT_W-1:0]; res_valid = 1'b1; end
                            OP_AND: begin res_out = a_in & b_in; res_valid = 1'b1; end
                            OP_OR:  begin res_out = a_in | b_in; res_valid = 1'b1; end
                            OP_XOR: begin res_out = a_in ^ b_in; res_valid = 1'b1; end
                            OP_SLT:  if (last) begin res_out = DIGIT_W'(lt_now);  res_valid = 1'b1; end
                            OP_SLTU: if (last) begin res_out = DIGIT_W'(ltu_now); res_valid = 1'b1; end
                            default: res_valid = !is_shift;
                        endcase
                    end
                end
`ifdef NANOV_SHIFT_EN
                OUT: begin
                    if (en) begin
                        res_out   = buf_q[DIGIT_W-1:0];
                        res_valid = 1'b1;
                        done      = last;
                    end
                end
`endif
                default: ;
            endcase
        end
        flag_eq  = rst ? 1'b0 : (done ? cur_eq  : h_eq);
        flag_lt  = rst ? 1'b0 : (done ? cur_lt  : h_lt);
        flag_ltu = rst ? 1'b0 : (done ? cur_ltu : h_ltu);
    end

    // Datapath registers: beat counter, carries, flag accumulators, shift buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= OP_ADD;
            carry  <= 1'b0;
            fcarry <= 1'b0;
            feq    <= 1'b0;
            h_eq   <= 1'b0;
            h_lt   <= 1'b0;
            h_ltu  <= 1'b0;
`ifdef NANOV_SHIFT_EN
            shamt_q <= '0;
            buf_q   <= '0;
            p_eq    <= 1'b0;
            p_lt    <= 1'b0;
            p_ltu   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        op_q <= op_t'(op);
`ifdef NANOV_SHIFT_EN
                        shamt_q <= shamt;
`endif
                    end
                end
                RUN: begin
                    if (en) begin
                        cnt    <= last ? '0 : cnt + 1'b1;
                        carry  <= add_full[DIGIT_W];
                        fcarry <= sub_full[DIGIT_W];
                        feq    <= eq_now;
`ifdef NANOV_SHIFT_EN
                        buf_q <= last ? shifted : buf_in;
                        if (last) begin
                            p_eq  <= eq_now;
                            p_lt  <= lt_now;
                            p_ltu <= ltu_now;
                        end
`endif
                    end
                end
`ifdef NANOV_SHIFT_EN
                OUT: begin
                    if (en) begin
                        cnt   <= last ? '0 : cnt + 1'b1;
                        buf_q <= {{DIGIT_W{1'b0}}, buf_q[XLEN-1:DIGIT_W]};
                    end
                end
`endif
                default: cnt <= '0;
            endcase
            if (done) begin
                h_eq  <= cur_eq;
                h_lt  <= cur_lt;
                h_ltu <= cur_ltu;
            end
        end
    end

endmodule

// File: doc/nanov_digit_alu.md
NANOV_DIGIT_ALU -- requirements
Module: nanov_digit_alu

Interface
REQ-001 SHALL have parameter DIGIT_W, default 1: bits per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter XLEN, default 32: operand width; beats per operand N = XLEN/DIGIT_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin operation; sampled only when busy low.
REQ-006 SHALL have port op  input  4  operation code, captured on accepted start.
REQ-007 SHALL have port shamt  input  5  shift amount, captured on accepted start.
REQ-008 SHALL have port en  input  1  beat enable; low stalls the operation.
REQ-009 SHALL have port a_in, b_in  input  DIGIT_W each  operand digits, LSB-first, one per enabled beat.
REQ-010 SHALL have port res_out  output  DIGIT_W  result digit, LSB-first.
REQ-011 SHALL have port res_valid  output  1  res_out valid this cycle.
REQ-012 SHALL have port busy, done  output  1 each  operation in progress / final beat completed.
REQ-013 SHALL have port flag_eq, flag_lt, flag_ltu  output  1 each  a==b, signed a<b, unsigned a<b; valid when done high.

Function
REQ-014 SHALL encode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10-15 reserved.
REQ-015 SHALL use states IDLE, RUN, OUT; IDLE->RUN on start; RUN->IDLE after N enabled beats (non-shift ops); RUN->OUT after N enabled beats (shift ops); OUT->IDLE after N enabled beats.
REQ-016 SHALL accept start the cycle after start is sampled high with busy low; first operand beat is the following enabled cycle.
REQ-017 SHALL hold beat counter, carry, flag state and buffer unchanged, and drive res_valid low, on any cycle en is low.
REQ-018 ADD/SUB/AND/OR/XOR SHALL output each result digit combinationally in the same enabled beat its operand digits arrive (zero latency), res_valid high for those beats.
REQ-019 ADD/SUB SHALL propagate carry across beats via a carry register; SUB carry-in at beat 0 is 1 with b inverted; result wraps modulo 2^XLEN.
REQ-020 Flags SHALL be computed on every op from an internal a-b path independent of op; flag_lt from sign bits and borrow on final beat.
REQ-021 SLT/SLTU SHALL stream N beats with res_valid low; done beat presents flag_lt/flag_ltu as the result bit.
REQ-022 Shift ops SHALL buffer a_in into an XLEN-bit register during RUN (res_valid low), then output the shifted value during OUT; SRA fills with a bit XLEN-1.
REQ-023 Reserved ops SHALL stream N beats of res_out = 0 with res_valid high.
REQ-024 done SHALL pulse high for one cycle coincident with the last enabled beat of the operation; busy SHALL remain high that cycle and fall the next.
REQ-025 start while busy high SHALL be ignored, including in the done cycle.
REQ-026 flag outputs SHALL hold their values from the last done until the next done.

Reset
REQ-027 rst SHALL force IDLE, counter 0, carry 0, buffer 0, busy 0, done 0, res_valid 0, res_out 0, all flags 0.
REQ-028 rst asserted mid-operation SHALL abort it with no done pulse; rst takes priority over start and en.

Configuration
REQ-029 Macro NANOV_SHIFT_EN: defined -> shift ops, OUT state and XLEN-bit buffer present per REQ-022; undefined -> ops 7-9 behave as reserved (REQ-023), no buffer or OUT state instantiated.

Verification
REQ-030 DIGIT_W=4, ADD a=0x0000_FFFF b=0x0000_0001, en constant high -> res_out digits 0,0,0,0,1,0,0,0 across 8 beats; done on beat 8; flag_ltu=0.
REQ-031 DIGIT_W=1, SUB a=5 b=7 -> result 0xFFFF_FFFE; flag_lt=1, flag_ltu=1, flag_eq=0 at done.
REQ-032 DIGIT_W=4, SRA a=0x8000_0010 shamt=4 with NANOV_SHIFT_EN -> 8 beats res_valid low, then 0xF800_0001 over 8 beats; done on 16th enabled beat.
REQ-033 DIGIT_W=2, XOR with en toggling every other cycle -> result 32-bit correct, res_valid only on en-high cycles, done after 16 enabled beats.
REQ-034 rst pulsed on beat 3 of ADD, then start SLTU a=3 b=0xFFFF_FFFF -> no done for aborted op; second op done with flag_ltu=1, flag_lt=0.
REQ-035 start held high continuously across two ADDs -> second start accepted only the cycle after busy falls; start during done cycle ignored.
